// File: rtl/mouse_delta_accum_pkg.sv
// Shared types and helpers for the mouse delta accumulator.
// Latency: none (types, constants and a combinational clamp function).
// Backpressure: none.
// Contents: port-ownership state enum, accumulator/snapshot/delta widths, clamp helper.
package mouse_delta_accum_pkg;

  typedef enum logic {
    INACTIVE = 1'b0,
    ACTIVE   = 1'b1
  } mouse_state_e;

  localparam int ACC_W   = 11;
  localparam int SNAP_W  = 8;
  localparam int DELTA_W = 9;

  typedef struct packed {
    logic                    hit;
    logic signed [ACC_W-1:0] val;
  } clamp_t;

  // Clamp v into [-lim-1, +lim] and report whether the clamp engaged.
  function automatic clamp_t clamp_acc(input logic signed [ACC_W-1:0] v, input int lim);
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    clamp_t                  r;
    hi    = ACC_W'(lim);
    lo    = ~hi;  // two's complement: ~hi == -hi-1
    r.hit = 1'b0;
    r.val = v;
    if (v > hi) begin
      r.val = hi;
      r.hit = 1'b1;
    end else if (v < lo) begin
      r.val = lo;
      r.hit = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mouse_axis_acc.sv
// One mouse axis: add delta on strobe, clamp, snapshot-and-clear on request.
// Latency: accumulator and snapshot update one cycle after strobe/snap request.
// Backpressure: none; every strobe and snap request is taken in its cycle.
// Ports: clk_i/reset_i; delta_i (signed 9b), strobe_i, snap_req_i, clear_i;
//        snap_o (8b snapshot register), sat_hit_o (combinational clamp event).
module mouse_axis_acc
  import mouse_delta_accum_pkg::*;
#(
  parameter bit NEGATE  = 1'b0,
  parameter int SAT_LIM = 127
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic signed [DELTA_W-1:0] delta_i,
  input  logic                      strobe_i,
  input  logic                      snap_req_i,
  input  logic                      clear_i,
  output logic        [SNAP_W-1:0]  snap_o,
  output logic                      sat_hit_o
);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] delta_ext;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] sum;
  logic        [SNAP_W-1:0] snap_q, snap_d;
  clamp_t                  cl;

  always_comb begin
    delta_ext = {{(ACC_W-DELTA_W){delta_i[DELTA_W-1]}}, delta_i};
    // Negation happens after widening so -256 becomes +256 rather than wrapping.
    if (NEGATE) delta_ext = -delta_ext;

    // A snapshot or a port hand-over empties the accumulator; a coincident
    // strobe then lands on an empty accumulator.
    base      = (snap_req_i || clear_i) ? '0 : acc_q;
    sum       = base + delta_ext;
    cl        = clamp_acc(sum, SAT_LIM);

    acc_d     = base;
    sat_hit_o = 1'b0;
    if (strobe_i && !clear_i) begin
      acc_d     = cl.val;
      sat_hit_o = cl.hit;
    end

    // Snapshot always takes the pre-add value.
    snap_d = snap_req_i ? acc_q[SNAP_W-1:0] : snap_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q  <= '0;
      snap_q <= '0;
    end else begin
      acc_q  <= acc_d;
      snap_q <= snap_d;
    end
  end

  assign snap_o = snap_q;

endmodule

// File: rtl/mouse_delta_accum.sv
// Accumulates PS/2 mouse deltas for an MSX-style port, with snapshot-on-read and port ownership FSM.
// Latency: accumulators, snapshots, buttons and mouse_en all update one cycle after their inputs.
// Backpressure: none; strobes and snap requests are never stalled or dropped.
// Ports: clk_sys, reset (sync, active-high); mouse_x/y/flags/strobe from user_io; joy_active, snap_req
//        from the port encoder; snap_x/y + snap_valid, btn_n, mouse_en, sat_flag outputs.
module mouse_delta_accum
  import mouse_delta_accum_pkg::*;
#(
  parameter bit INVERT_X     = 1'b1,
  parameter int SAT_LIM      = 127,
  parameter int IDLE_TIMEOUT = 0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [8:0]  mouse_x,
  input  logic [8:0]  mouse_y,
  input  logic [7:0]  mouse_flags,
  input  logic        mouse_strobe,
  input  logic        joy_active,
  input  logic        snap_req,
  output logic [7:0]  snap_x,
  output logic [7:0]  snap_y,
  output logic        snap_valid,
  output logic [1:0]  btn_n,
  output logic        mouse_en,
  output logic        sat_flag
);

  localparam int IDLE_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);

  mouse_state_e       state_q, state_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic [1:0]         btn_n_q, btn_n_d;
  logic               snap_valid_q;
  logic               sat_q, sat_d;
  logic               timeout_hit;
  logic               acc_clear;
  logic               sat_hit_x, sat_hit_y;
  logic               unused_flags;

  assign unused_flags = ^mouse_flags[7:2];

  // Idle counter: zeroed by a strobe, otherwise counts up and parks at the limit.
  always_comb begin
    idle_d = idle_q;
    if (mouse_strobe)          idle_d = '0;
    else if (idle_q != IDLE_MAX) idle_d = idle_q + IDLE_W'(1);
    // The drop happens on the same edge the counter reaches the limit.
    timeout_hit = (IDLE_TIMEOUT != 0) && (idle_d == IDLE_MAX);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INACTIVE: if (mouse_strobe) state_d = ACTIVE;
      ACTIVE:   if (!mouse_strobe && (joy_active || timeout_hit)) state_d = INACTIVE;
      default:  state_d = INACTIVE;
    endcase
    // Stale motion must not leak out after the joystick takes the port.
    acc_clear = (state_q == ACTIVE) && (state_d == INACTIVE);
  end

  always_comb begin
    btn_n_d = {~mouse_flags[1], ~mouse_flags[0]};
    sat_d   = sat_q;
    if (snap_req)              sat_d = 1'b0;
    if (sat_hit_x || sat_hit_y) sat_d = 1'b1;  // a fresh clamp outranks the clear
  end

  mouse_axis_acc #(.NEGATE(INVERT_X), .SAT_LIM(SAT_LIM)) u_acc_x (
    .clk_i      (clk_sys),
    .reset_i    (reset),
    .delta_i    ($signed(mouse_x)),
    .strobe_i   (mouse_strobe),
    .snap_req_i (snap_req),
    .clear_i    (acc_clear),
    .snap_o     (snap_x),
    .sat_hit_o  (sat_hit_x)
  );

  mouse_axis_acc #(.NEGATE(1'b0), .SAT_LIM(SAT_LIM)) u_acc_y (
    .clk_i      (clk_sys),
    .reset_i    (reset),
    .delta_i    ($signed(mouse_y)),
    .strobe_i   (mouse_strobe),
    .snap_req_i (snap_req),
    .clear_i    (acc_clear),
    .snap_o     (snap_y),
    .sat_hit_o  (sat_hit_y)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= INACTIVE;
      idle_q       <= '0;
      btn_n_q      <= 2'b11;
      snap_valid_q <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idle_q       <= idle_d;
      btn_n_q      <= btn_n_d;
      snap_valid_q <= snap_req;
      sat_q        <= sat_d;
    end
  end

  assign mouse_en   = (state_q == ACTIVE);
  assign btn_n      = btn_n_q;
  assign snap_valid = snap_valid_q;
  assign sat_flag   = sat_q;

endmodule
